// File: rtl/regfile_hilo_pkg.sv
// rtl/regfile_hilo_pkg.sv - shared types for the architectural register file
package regfile_hilo_pkg;

   typedef logic [31:0] word_t;
   typedef logic [4:0]  creg_addr_t;

   // r0 is hardwired to zero, so only r1..r31 hold state
   localparam int NGPR = 31;

   // One retiring write slot; also the payload the forwarding network carries
   typedef struct packed {
      logic       wen;
      creg_addr_t waddr;
      word_t      wdata;
      logic       hi_wen;
      logic       lo_wen;
      word_t      hi_wdata;
      word_t      lo_wdata;
   } retire_wr_t;

endpackage

// File: rtl/regfile_hilo_write_merge.sv
// rtl/regfile_hilo_write_merge.sv - resolves two retire slots into per-register write selects
module regfile_hilo_write_merge #(
   parameter int NREG = 31,
   parameter int AW   = 5,
   parameter int BASE = 1
) (
   input  logic [1:0]         wen_i,
   input  logic [1:0][AW-1:0] waddr_i,
   output logic [NREG-1:0]    we_o,
   output logic [NREG-1:0]    sel1_o
);

   // Entry k stands for address k+BASE; slot 1 is the younger write and wins a tie
   for (genvar k = 0; k < NREG; k++) begin : g_reg
      logic hit0;
      logic hit1;
      assign hit0      = wen_i[0] && (waddr_i[0] == AW'(k + BASE));
      assign hit1      = wen_i[1] && (waddr_i[1] == AW'(k + BASE));
      assign we_o[k]   = hit0 | hit1;
      assign sel1_o[k] = hit1;
   end

endmodule

// File: rtl/regfile_hilo.sv
// rtl/regfile_hilo.sv - GPR and HI/LO architectural state with two retire write slots
module regfile_hilo
   import regfile_hilo_pkg::*;
#(
   parameter int NREAD         = 4,
   parameter int NWRITE        = 2,
   parameter int WRITE_THROUGH = 0
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic [NREAD-1:0][4:0]   reg_addr,
   output logic [NREAD-1:0][31:0]  reg_data,
   input  logic [1:0]              hiloread,
   output logic [31:0]             hi_data,
   output logic [31:0]             lo_data,
   input  logic [NWRITE-1:0]       reg_wen,
   input  logic [NWRITE-1:0][4:0]  reg_waddr,
   input  logic [NWRITE-1:0][31:0] reg_wdata,
   input  logic [NWRITE-1:0]       hi_wen,
   input  logic [NWRITE-1:0]       lo_wen,
   input  logic [NWRITE-1:0][31:0] hi_wdata,
   input  logic [NWRITE-1:0][31:0] lo_wdata
);

   retire_wr_t [1:0]          wr;
   logic [NGPR-1:0]           gpr_we;
   logic [NGPR-1:0]           gpr_sel1;
   logic [NGPR-1:0][31:0]     gpr_d;
   logic [NGPR-1:0][31:0]     gpr_q;
   logic [0:0]                hi_we;
   logic [0:0]                hi_sel1;
   logic [0:0]                lo_we;
   logic [0:0]                lo_sel1;
   word_t                     hi_d;
   word_t                     hi_q;
   word_t                     lo_d;
   word_t                     lo_q;

   for (genvar s = 0; s < 2; s++) begin : g_slot
      assign wr[s] = '{wen:      reg_wen[s],
                       waddr:    reg_waddr[s],
                       wdata:    reg_wdata[s],
                       hi_wen:   hi_wen[s],
                       lo_wen:   lo_wen[s],
                       hi_wdata: hi_wdata[s],
                       lo_wdata: lo_wdata[s]};
   end

   regfile_hilo_write_merge #(.NREG(NGPR), .AW(5), .BASE(1)) u_gpr_merge (
      .wen_i   ({wr[1].wen, wr[0].wen}),
      .waddr_i ({wr[1].waddr, wr[0].waddr}),
      .we_o    (gpr_we),
      .sel1_o  (gpr_sel1)
   );

   // HI and LO are single-entry files, so the address compare is trivially true
   regfile_hilo_write_merge #(.NREG(1), .AW(1), .BASE(0)) u_hi_merge (
      .wen_i   ({wr[1].hi_wen, wr[0].hi_wen}),
      .waddr_i ('0),
      .we_o    (hi_we),
      .sel1_o  (hi_sel1)
   );

   regfile_hilo_write_merge #(.NREG(1), .AW(1), .BASE(0)) u_lo_merge (
      .wen_i   ({wr[1].lo_wen, wr[0].lo_wen}),
      .waddr_i ('0),
      .we_o    (lo_we),
      .sel1_o  (lo_sel1)
   );

   // Next value per GPR picks the winning slot's data
   always_comb begin
      for (int k = 0; k < NGPR; k++) begin
         gpr_d[k] = gpr_sel1[k] ? wr[1].wdata : wr[0].wdata;
      end
   end

   assign hi_d = hi_sel1[0] ? wr[1].hi_wdata : wr[0].hi_wdata;
   assign lo_d = lo_sel1[0] ? wr[1].lo_wdata : wr[0].lo_wdata;

   // Architectural state; reset clears everything and drops in-flight writes
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         gpr_q <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
      end else begin
         for (int k = 0; k < NGPR; k++) begin
            if (gpr_we[k]) gpr_q[k] <= gpr_d[k];
         end
         if (hi_we[0]) hi_q <= hi_d;
         if (lo_we[0]) lo_q <= lo_d;
      end
   end

   // GPR read ports; r0 reads zero and the write-through variant bypasses retiring data
   always_comb begin
      for (int i = 0; i < NREAD; i++) begin
         reg_data[i] = '0;
         if (resetn && (reg_addr[i] != 5'd0)) begin
            if ((WRITE_THROUGH != 0) && gpr_we[reg_addr[i] - 5'd1])
               reg_data[i] = gpr_d[reg_addr[i] - 5'd1];
            else
               reg_data[i] = gpr_q[reg_addr[i] - 5'd1];
         end
      end
   end

   assign hi_data = !resetn ? '0 : ((WRITE_THROUGH != 0) && hi_we[0]) ? hi_d : hi_q;
   assign lo_data = !resetn ? '0 : ((WRITE_THROUGH != 0) && lo_we[0]) ? lo_d : lo_q;

   a_en_known: assert property (@(posedge clk) !$isunknown({reg_wen, hi_wen, lo_wen}));
   a_hiloread_known: assert property (@(posedge clk) !$isunknown(hiloread));
   for (genvar s = 0; s < 2; s++) begin : g_addr_chk
      a_waddr_known: assert property (@(posedge clk) reg_wen[s] |-> !$isunknown(reg_waddr[s]));
   end

endmodule

// File: tb/tb_regfile_hilo.sv
// tb/tb_regfile_hilo.sv - self-checking bench for regfile_hilo, both write-through settings
module tb_regfile_hilo;
   import regfile_hilo_pkg::*;

   localparam int NREAD = 4;

   logic                   clk = 1'b0;
   logic                   resetn;
   logic [NREAD-1:0][4:0]  reg_addr;
   logic [NREAD-1:0][31:0] rd0, rd1;
   logic [1:0]             hiloread;
   logic [31:0]            hi0, hi1, lo0, lo1;
   logic [1:0]             reg_wen;
   logic [1:0][4:0]        reg_waddr;
   logic [1:0][31:0]       reg_wdata;
   logic [1:0]             hi_wen, lo_wen;
   logic [1:0][31:0]       hi_wdata, lo_wdata;

   int nvec  = 0;
   int nfail = 0;

   word_t m_gpr [32];
   word_t m_hi, m_lo;

   typedef struct {
      logic [1:0]       wen;
      logic [1:0][4:0]  wa;
      logic [1:0][31:0] wd;
      logic [1:0]       hw, lw;
      logic [1:0][31:0] hd, ld;
      logic [4:0]       rd;
      word_t            e_r0, e_r1, e_h0, e_h1, e_l0, e_l1;
   } vec_t;

   vec_t vq[$];

   always #5 clk = ~clk;

   regfile_hilo #(.NREAD(NREAD), .NWRITE(2), .WRITE_THROUGH(0)) dut (
      .clk(clk), .resetn(resetn), .reg_addr(reg_addr), .reg_data(rd0),
      .hiloread(hiloread), .hi_data(hi0), .lo_data(lo0),
      .reg_wen(reg_wen), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
      .hi_wen(hi_wen), .lo_wen(lo_wen), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata)
   );

   regfile_hilo #(.NREAD(NREAD), .NWRITE(2), .WRITE_THROUGH(1)) dut_wt (
      .clk(clk), .resetn(resetn), .reg_addr(reg_addr), .reg_data(rd1),
      .hiloread(hiloread), .hi_data(hi1), .lo_data(lo1),
      .reg_wen(reg_wen), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
      .hi_wen(hi_wen), .lo_wen(lo_wen), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata)
   );

   task automatic cmp(input string nm, input word_t act, input word_t exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Architectural value after this cycle's writes, applied oldest first
   function automatic word_t post_gpr(input logic [4:0] a);
      word_t v = m_gpr[a];
      for (int s = 0; s < 2; s++)
         if (reg_wen[s] && reg_waddr[s] == a) v = reg_wdata[s];
      return (a == 5'd0) ? 32'd0 : v;
   endfunction

   function automatic word_t post_hi();
      word_t v = m_hi;
      for (int s = 0; s < 2; s++) if (hi_wen[s]) v = hi_wdata[s];
      return v;
   endfunction

   function automatic word_t post_lo();
      word_t v = m_lo;
      for (int s = 0; s < 2; s++) if (lo_wen[s]) v = lo_wdata[s];
      return v;
   endfunction

   task automatic commit_model();
      word_t h = post_hi();
      word_t l = post_lo();
      for (int a = 1; a < 32; a++) m_gpr[a] = post_gpr(5'(a));
      m_hi = h;
      m_lo = l;
   endtask

   task automatic clear_model();
      for (int a = 0; a < 32; a++) m_gpr[a] = '0;
      m_hi = '0;
      m_lo = '0;
   endtask

   task automatic idle_writes();
      reg_wen = '0; reg_waddr = '0; reg_wdata = '0;
      hi_wen = '0; lo_wen = '0; hi_wdata = '0; lo_wdata = '0;
   endtask

   // Inputs are set just after a rising edge; compare mid-cycle, then clock once
   task automatic check_cycle(input string nm);
      #2;
      for (int i = 0; i < NREAD; i++) begin
         cmp($sformatf("%s port%0d r%0d wt0", nm, i, reg_addr[i]), rd0[i],
             resetn ? m_gpr[reg_addr[i]] : 32'd0);
         cmp($sformatf("%s port%0d r%0d wt1", nm, i, reg_addr[i]), rd1[i],
             resetn ? post_gpr(reg_addr[i]) : 32'd0);
      end
      cmp({nm, " hi wt0"}, hi0, resetn ? m_hi : 32'd0);
      cmp({nm, " hi wt1"}, hi1, resetn ? post_hi() : 32'd0);
      cmp({nm, " lo wt0"}, lo0, resetn ? m_lo : 32'd0);
      cmp({nm, " lo wt1"}, lo1, resetn ? post_lo() : 32'd0);
      @(posedge clk);
      if (resetn) commit_model();
      #1;
   endtask

   task automatic add(input logic [1:0] wen, input logic [4:0] a0, a1,
                      input word_t d0, d1, input logic [1:0] hw, lw,
                      input word_t h0, h1, l0, l1, input logic [4:0] rd,
                      input word_t er0, er1, eh0, eh1, el0, el1);
      vec_t v;
      v.wen = wen; v.wa[0] = a0; v.wa[1] = a1; v.wd[0] = d0; v.wd[1] = d1;
      v.hw = hw; v.lw = lw; v.hd[0] = h0; v.hd[1] = h1; v.ld[0] = l0; v.ld[1] = l1;
      v.rd = rd; v.e_r0 = er0; v.e_r1 = er1;
      v.e_h0 = eh0; v.e_h1 = eh1; v.e_l0 = el0; v.e_l1 = el1;
      vq.push_back(v);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t v;
      resetn = 1'b1; hiloread = '0; reg_addr = '0;
      idle_writes();
      clear_model();
      #1 resetn = 1'b0;
      @(posedge clk); #1;

      // Reset held: every address reads zero, even with writes enabled
      for (int g = 0; g < 8; g++) begin
         for (int i = 0; i < NREAD; i++) reg_addr[i] = 5'(g * 4 + i);
         reg_wen = 2'b11; reg_waddr[0] = 5'(g * 4 + 1); reg_waddr[1] = 5'(g * 4 + 2);
         reg_wdata[0] = $urandom; reg_wdata[1] = $urandom;
         hi_wen = 2'b01; lo_wen = 2'b10; hi_wdata[0] = $urandom; lo_wdata[1] = $urandom;
         check_cycle($sformatf("reset g%0d", g));
      end
      resetn = 1'b1;
      idle_writes();
      for (int g = 0; g < 8; g++) begin
         for (int i = 0; i < NREAD; i++) reg_addr[i] = 5'(g * 4 + i);
         check_cycle($sformatf("released g%0d", g));
      end

      // Directed table: wen a0 a1 d0 d1 hw lw h0 h1 l0 l1 rd | r_wt0 r_wt1 hi_wt0 hi_wt1 lo_wt0 lo_wt1
      add(2'b01, 5, 0, 32'hDEADBEEF, 0, 2'b00, 2'b00, 0, 0, 0, 0, 5, 0, 32'hDEADBEEF, 0, 0, 0, 0);
      add(2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, 0);
      add(2'b11, 7, 7, 32'h1111, 32'h2222, 2'b00, 2'b00, 0, 0, 0, 0, 7, 0, 32'h2222, 0, 0, 0, 0);
      add(2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 7, 32'h2222, 32'h2222, 0, 0, 0, 0);
      add(2'b10, 0, 0, 0, 32'hFFFFFFFF, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(2'b00, 0, 0, 0, 0, 2'b01, 2'b10, 32'hA, 0, 0, 32'hB, 5,
          32'hDEADBEEF, 32'hDEADBEEF, 0, 32'hA, 0, 32'hB);
      add(2'b00, 0, 0, 0, 0, 2'b11, 2'b00, 32'h1, 32'h2, 0, 0, 7,
          32'h2222, 32'h2222, 32'hA, 32'h2, 32'hB, 32'hB);
      add(2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 7, 32'h2222, 32'h2222, 2, 2, 32'hB, 32'hB);
      add(2'b11, 7, 9, 32'h3333, 32'h4444, 2'b00, 2'b00, 0, 0, 0, 0, 9, 0, 32'h4444, 2, 2, 32'hB, 32'hB);
      add(2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 7, 32'h3333, 32'h3333, 2, 2, 32'hB, 32'hB);
      add(2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 9, 32'h4444, 32'h4444, 2, 2, 32'hB, 32'hB);
      add(2'b01, 31, 0, 32'hCAFE0031, 0, 2'b00, 2'b00, 0, 0, 0, 0, 31, 0, 32'hCAFE0031, 2, 2, 32'hB, 32'hB);
      add(2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 31, 32'hCAFE0031, 32'hCAFE0031, 2, 2, 32'hB, 32'hB);
      add(2'b00, 5, 5, 32'h12345678, 32'h87654321, 2'b00, 2'b00, 32'h77, 32'h88, 32'h99, 32'hAA, 5,
          32'hDEADBEEF, 32'hDEADBEEF, 2, 2, 32'hB, 32'hB);

      foreach (vq[n]) begin
         v = vq[n];
         reg_wen = v.wen; reg_waddr = v.wa; reg_wdata = v.wd;
         hi_wen = v.hw; lo_wen = v.lw; hi_wdata = v.hd; lo_wdata = v.ld;
         for (int i = 0; i < NREAD; i++) reg_addr[i] = v.rd;
         #2;
         for (int i = 0; i < NREAD; i++) begin
            cmp($sformatf("vec%0d port%0d wt0", n, i), rd0[i], v.e_r0);
            cmp($sformatf("vec%0d port%0d wt1", n, i), rd1[i], v.e_r1);
         end
         cmp($sformatf("vec%0d hi wt0", n), hi0, v.e_h0);
         cmp($sformatf("vec%0d hi wt1", n), hi1, v.e_h1);
         cmp($sformatf("vec%0d lo wt0", n), lo0, v.e_l0);
         cmp($sformatf("vec%0d lo wt1", n), lo1, v.e_l1);
         @(posedge clk);
         commit_model();
         #1;
      end
      idle_writes();

      // Reset asserted between edges while a write is pending
      for (int i = 0; i < NREAD; i++) reg_addr[i] = 5'd9;
      reg_wen = 2'b01; reg_waddr[0] = 5'd9; reg_wdata[0] = 32'h55;
      check_cycle("async wr55");
      idle_writes();
      check_cycle("async rd55");
      reg_wen = 2'b01; reg_waddr[0] = 5'd9; reg_wdata[0] = 32'h77;
      hi_wen = 2'b01; hi_wdata[0] = 32'h77;
      #2;
      resetn = 1'b0;
      clear_model();
      #1;
      cmp("async r9 wt0 during reset", rd0[2], 32'd0);
      cmp("async r9 wt1 during reset", rd1[2], 32'd0);
      cmp("async hi wt1 during reset", hi1, 32'd0);
      @(posedge clk); #1;
      resetn = 1'b1;
      idle_writes();
      check_cycle("async after release");
      reg_wen = 2'b10; reg_waddr[1] = 5'd9; reg_wdata[1] = 32'h99;
      check_cycle("async first write");
      idle_writes();
      check_cycle("async first write read");

      // Random traffic with narrow addresses to provoke same-register conflicts
      for (int n = 0; n < 400; n++) begin
         for (int s = 0; s < 2; s++) begin
            reg_wen[s]   = 1'($urandom_range(0, 1));
            reg_waddr[s] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            reg_wdata[s] = $urandom;
            hi_wen[s]    = 1'($urandom_range(0, 1));
            lo_wen[s]    = 1'($urandom_range(0, 1));
            hi_wdata[s]  = $urandom;
            lo_wdata[s]  = $urandom;
         end
         hiloread = 2'($urandom);
         for (int i = 0; i < NREAD; i++)
            reg_addr[i] = ($urandom_range(0, 1) == 1) ? reg_waddr[$urandom_range(0, 1)]
                                                       : 5'($urandom);
         check_cycle($sformatf("rand%0d", n));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
